// File: rtl/fm_phase_accumulator_if.sv
// ---------------------------------------------------------------------------
// fm_phase_accumulator_if
//
// Minimal AXI-Stream bundle used on both sides of the FM phase accumulator.
// The same interface type carries the 32-bit increment stream in and the
// 16-bit phase stream out; DATA_WIDTH is set per instance.
//
// Signals:
//   tvalid  producer -> consumer   beat valid
//   tready  consumer -> producer   consumer can take the beat
//   tdata   producer -> consumer   payload, DATA_WIDTH bits
//   tuser   producer -> consumer   sideband flag (phase wrap on the output)
//
// Modports:
//   master  drives tvalid/tdata/tuser, samples tready
//   slave   samples tvalid/tdata/tuser, drives tready
// ---------------------------------------------------------------------------
interface fm_phase_accumulator_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        output tready
    );

endinterface : fm_phase_accumulator_if

// File: rtl/fm_phase_accumulator.sv
// ---------------------------------------------------------------------------
// fm_phase_accumulator
//
// Phase accumulator feeding the sine LUT / DDS. Each accepted increment is
// added modulo 2^ACC_WIDTH to the running accumulator, a static phase offset
// is added to the new accumulator value, and the top M_AXIS_TDATA_WIDTH bits
// of that sum leave on the output stream. tuser on the output marks the beat
// on which the accumulator itself carried out (the offset addition never
// sets it).
//
// A two-entry output buffer (output register + skid register) lets
// S_AXIS_tready be a pure register while still sustaining one beat per cycle
// when the downstream is always ready.
//
// Ports:
//   aclk          in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   phase_offset  in   ACC_WIDTH offset, sampled on each accepted beat
//   acc_clear     in   restart accumulation from zero on next accepted beat
//   s_axis        slave  increment stream (tdata = unsigned increment,
//                        tuser ignored)
//   m_axis        master phase stream (tdata = truncated phase,
//                        tuser = accumulator wrap flag)
// ---------------------------------------------------------------------------
module fm_phase_accumulator #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int ACC_WIDTH          = 32,
    parameter int M_AXIS_TDATA_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic [ACC_WIDTH-1:0]   phase_offset,
    input  logic                   acc_clear,
    fm_phase_accumulator_if.slave  s_axis,
    fm_phase_accumulator_if.master m_axis
);

    // Occupancy of the output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // output register invalid
        ST_ONE   = 2'd1,   // output register valid, skid empty
        ST_FULL  = 2'd2    // output and skid registers both valid
    } buf_state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    buf_state_t                    r_state;
    logic                          r_s_tready;
    logic [ACC_WIDTH-1:0]          r_acc;
    logic                          r_clear_pending;
    logic [M_AXIS_TDATA_WIDTH-1:0] r_out_data;
    logic                          r_out_user;
    logic [M_AXIS_TDATA_WIDTH-1:0] r_skid_data;
    logic                          r_skid_user;

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    logic                          w_accept;
    logic                          w_clear_now;
    logic [ACC_WIDTH-1:0]          w_base;
    logic [ACC_WIDTH:0]            w_sum;
    logic [ACC_WIDTH-1:0]          w_acc_next;
    logic                          w_carry;
    logic [ACC_WIDTH-1:0]          w_phase;
    logic [M_AXIS_TDATA_WIDTH-1:0] w_result_data;
    logic                          w_unused;

    assign w_accept = s_axis.tvalid & r_s_tready;

    // A clear raised in the same cycle as the accept applies to that beat,
    // so the pending flag and the live input are merged here.
    assign w_clear_now = r_clear_pending | acc_clear;
    assign w_base      = w_clear_now ? '0 : r_acc;

    // One extra bit on the sum captures the wrap carry; the increment is
    // zero-extended to the accumulator width.
    assign w_sum      = {1'b0, w_base} + (ACC_WIDTH + 1)'(s_axis.tdata);
    assign w_acc_next = w_sum[ACC_WIDTH-1:0];
    assign w_carry    = w_sum[ACC_WIDTH];

    // Offset is applied after accumulation and wraps silently; it never
    // feeds back into the accumulator or the carry flag.
    assign w_phase       = w_acc_next + phase_offset;
    assign w_result_data = w_phase[ACC_WIDTH-1 -: M_AXIS_TDATA_WIDTH];

    // Truncated phase LSBs and the input sideband are intentionally dropped.
    assign w_unused = s_axis.tuser ^ (^w_phase);

    // -----------------------------------------------------------------------
    // Buffer control: next state and register load enables
    // -----------------------------------------------------------------------
    buf_state_t                    w_state_next;
    logic                          w_load_out;
    logic                          w_out_from_skid;
    logic                          w_load_skid;
    logic [M_AXIS_TDATA_WIDTH-1:0] w_out_data_next;
    logic                          w_out_user_next;

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // that no path leaves a signal unassigned, which would infer a latch.
        w_state_next    = r_state;
        w_load_out      = 1'b0;
        w_out_from_skid = 1'b0;
        w_load_skid     = 1'b0;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next = ST_ONE;
                    w_load_out   = 1'b1;
                end
            end

            ST_ONE: begin
                if (w_accept) begin
                    if (m_axis.tready) begin
                        // Current output leaves, new result takes its place.
                        w_load_out = 1'b1;
                    end else begin
                        // Output is stalled: park the new result in the skid.
                        w_load_skid  = 1'b1;
                        w_state_next = ST_FULL;
                    end
                end else if (m_axis.tready) begin
                    w_state_next = ST_EMPTY;
                end
            end

            ST_FULL: begin
                // S_AXIS_tready is low here, so no accept can coincide.
                if (m_axis.tready) begin
                    w_load_out      = 1'b1;
                    w_out_from_skid = 1'b1;
                    w_state_next    = ST_ONE;
                end
            end

            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    assign w_out_data_next = w_out_from_skid ? r_skid_data : w_result_data;
    assign w_out_user_next = w_out_from_skid ? r_skid_user : w_carry;

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // samples the pre-edge value of every other register.
        if (reset) begin
            r_state         <= ST_EMPTY;
            r_s_tready      <= 1'b0;
            r_acc           <= '0;
            r_clear_pending <= 1'b0;
            r_out_data      <= '0;
            r_out_user      <= 1'b0;
            // NOTE: the skid payload is only read while the state says it is
            // valid, but it is cleared anyway so no stale beat survives reset.
            r_skid_data     <= '0;
            r_skid_user     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            // Registered ready: look ahead at the buffer state after this edge.
            r_s_tready <= (w_state_next != ST_FULL);

            if (w_accept) begin
                r_acc           <= w_acc_next;
                r_clear_pending <= 1'b0;
            end else if (acc_clear) begin
                r_clear_pending <= 1'b1;
            end

            if (w_load_out) begin
                r_out_data <= w_out_data_next;
                r_out_user <= w_out_user_next;
            end

            if (w_load_skid) begin
                r_skid_data <= w_result_data;
                r_skid_user <= w_carry;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign s_axis.tready = r_s_tready;
    assign m_axis.tvalid = (r_state != ST_EMPTY);
    assign m_axis.tdata  = r_out_data;
    assign m_axis.tuser  = r_out_user;

endmodule : fm_phase_accumulator

// File: tb/tb_fm_phase_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fm_phase_accumulator
//
// Self-checking bench for fm_phase_accumulator. A queue-based model tracks
// the beats held inside the DUT; a negedge process compares the DUT outputs
// with it every cycle. Directed sequences pin the model with literal values,
// then a randomized phase exercises backpressure, clears, offsets and reset.
// ---------------------------------------------------------------------------
module tb_fm_phase_accumulator;

    typedef struct packed {
        logic [15:0] data;
        logic        user;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [31:0] phase_offset;
    logic        acc_clear;

    fm_phase_accumulator_if #(.DATA_WIDTH(32)) s_if ();
    fm_phase_accumulator_if #(.DATA_WIDTH(16)) m_if ();

    fm_phase_accumulator #(
        .S_AXIS_TDATA_WIDTH (32),
        .ACC_WIDTH          (32),
        .M_AXIS_TDATA_WIDTH (16)
    ) dut (
        .aclk         (clk),
        .reset        (reset),
        .phase_offset (phase_offset),
        .acc_clear    (acc_clear),
        .s_axis       (s_if),
        .m_axis       (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: beats currently held by the DUT, in order.
    // -----------------------------------------------------------------------
    beat_t       held_q[$];
    beat_t       out_log[$];
    logic [31:0] m_acc;
    logic        m_pending;
    logic        m_tready;
    logic        model_live = 1'b0;
    int          n_accepts  = 0;

    always @(negedge clk) begin
        logic [32:0] sum;
        logic [31:0] base;
        logic [31:0] phase;
        beat_t       b;

        if (model_live) begin
            check("m_tvalid", 32'(m_if.tvalid), 32'(held_q.size() > 0));
            check("s_tready", 32'(s_if.tready), 32'(m_tready));
            if (held_q.size() > 0) begin
                check("m_tdata", 32'(m_if.tdata), 32'(held_q[0].data));
                check("m_tuser", 32'(m_if.tuser), 32'(held_q[0].user));
            end
        end

        // Predict the effect of the coming rising edge.
        if (reset) begin
            held_q.delete();
            m_acc      = '0;
            m_pending  = 1'b0;
            m_tready   = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (held_q.size() > 0 && m_if.tready)
                out_log.push_back(held_q.pop_front());
            if (s_if.tvalid && m_tready) begin
                base   = (m_pending || acc_clear) ? 32'h0 : m_acc;
                sum    = {1'b0, base} + {1'b0, s_if.tdata};
                m_acc  = sum[31:0];
                phase  = m_acc + phase_offset;
                b.data = phase[31:16];
                b.user = sum[32];
                held_q.push_back(b);
                m_pending = 1'b0;
                n_accepts++;
            end else if (acc_clear) begin
                m_pending = 1'b1;
            end
            m_tready = (held_q.size() < 2);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        acc_clear   = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    task automatic drain();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        acc_clear   = 1'b0;
        step(4);
    endtask

    task automatic start_log();
        out_log.delete();
        n_accepts = 0;
    endtask

    task automatic check_log(input string name, input logic [15:0] exp_d[],
                             input logic exp_u[]);
        check({name, " count"}, 32'(out_log.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < out_log.size(); i++) begin
            check($sformatf("%s data[%0d]", name, i), 32'(out_log[i].data), 32'(exp_d[i]));
            check($sformatf("%s user[%0d]", name, i), 32'(out_log[i].user), 32'(exp_u[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        phase_offset = '0;
        acc_clear    = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tuser   = 1'b0;
        m_if.tready  = 1'b1;
        step(2);
        check("reset tvalid", 32'(m_if.tvalid), 32'h0);
        check("reset tdata", 32'(m_if.tdata), 32'h0);
        check("reset tuser", 32'(m_if.tuser), 32'h0);
        check("reset s_tready", 32'(s_if.tready), 32'h0);
        reset = 1'b0;
        step(1);
        check("post-reset s_tready", 32'(s_if.tready), 32'h1);

        // T1: continuous increments, no backpressure, latency of one edge.
        do_reset();
        start_log();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h0001_0000;
        step(1);
        check("T1 first tvalid", 32'(m_if.tvalid), 32'h1);
        check("T1 first tdata", 32'(m_if.tdata), 32'h0001);
        step(5);
        drain();
        check_log("T1", '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // T2: quarter-turn increments, wrap flagged on the 4th beat only.
        do_reset();
        start_log();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h4000_0000;
        step(5);
        drain();
        check_log("T2", '{16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000},
                  '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        // T3: downstream stalls for 5 cycles; exactly two beats absorbed.
        do_reset();
        start_log();
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h0001_0000;
        step(5);
        check("T3 s_tready stalled", 32'(s_if.tready), 32'h0);
        check("T3 absorbed", 32'(n_accepts), 32'd2);
        check("T3 held tdata", 32'(m_if.tdata), 32'h0001);
        m_if.tready = 1'b1;
        step(4);
        drain();
        check_log("T3", '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // T4: half-turn offset, then removed mid-stream.
        do_reset();
        start_log();
        phase_offset = 32'h8000_0000;
        s_if.tvalid  = 1'b1;
        s_if.tdata   = 32'h0001_0000;
        step(3);
        phase_offset = 32'h0;
        step(2);
        drain();
        check_log("T4", '{16'h8001, 16'h8002, 16'h8003, 16'h0004, 16'h0005},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // T5: clear with a beat, then clear while idle before a beat.
        do_reset();
        start_log();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h0100_0000;
        step(3);
        acc_clear  = 1'b1;
        s_if.tdata = 32'h0200_0000;
        step(1);
        acc_clear   = 1'b0;
        s_if.tvalid = 1'b0;
        step(1);
        acc_clear = 1'b1;
        step(1);
        acc_clear   = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h0300_0000;
        step(1);
        drain();
        check_log("T5", '{16'h0100, 16'h0200, 16'h0300, 16'h0200, 16'h0300},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // T6: reset while the buffer is full.
        do_reset();
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h0001_0000;
        step(4);
        check("T6 full s_tready", 32'(s_if.tready), 32'h0);
        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        step(1);
        check("T6 reset tvalid", 32'(m_if.tvalid), 32'h0);
        check("T6 reset s_tready", 32'(s_if.tready), 32'h0);
        reset       = 1'b0;
        m_if.tready = 1'b1;
        step(1);
        start_log();
        s_if.tvalid = 1'b1;
        step(1);
        check("T6 first tvalid", 32'(m_if.tvalid), 32'h1);
        check("T6 first tdata", 32'(m_if.tdata), 32'h0001);
        drain();
        check("T6 log count", 32'(out_log.size()), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 599) == 0);
            s_if.tvalid = ($urandom_range(0, 3) != 0);
            s_if.tdata  = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 32'h00FF_FFFF));
            m_if.tready = ($urandom_range(0, 2) != 0);
            acc_clear   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0)
                phase_offset = $urandom();
            step(1);
        end
        reset = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fm_phase_accumulator
